// File: rtl/serpent_cbc_ctrl_if.sv
// Purpose : groups the block-level handshakes of serpent_cbc_ctrl: input block
//           (valid/ready/data), result (valid/ready/data) and the cipher-core drive.
// Ports   : slave modport is the controller side, master modport is the side that
//           feeds blocks, takes results and hosts the cipher core.
interface serpent_cbc_ctrl_if;
  // input block handshake
  logic         i_in_valid;
  logic         o_in_ready;
  logic [127:0] i_in_data;
  // result handshake
  logic         o_out_valid;
  logic         i_out_ready;
  logic [127:0] o_out_data;
  // cipher core drive and response
  logic         o_core_new_block;
  logic         o_core_dir;
  logic [127:0] o_core_data;
  logic         i_core_ready;
  logic [127:0] i_core_result;

  modport slave (
    input  i_in_valid, i_in_data, i_out_ready, i_core_ready, i_core_result,
    output o_in_ready, o_out_valid, o_out_data, o_core_new_block, o_core_dir, o_core_data
  );

  modport master (
    output i_in_valid, i_in_data, i_out_ready, i_core_ready, i_core_result,
    input  o_in_ready, o_out_valid, o_out_data, o_core_new_block, o_core_dir, o_core_data
  );
endinterface

// File: rtl/serpent_cbc_ctrl.sv
// Purpose : CBC (or ECB) chaining controller wrapped around a Serpent cipher core.
//           One block at a time: accept -> issue to core -> wait for core -> present result.
// Latency : accept to o_out_valid = 3 cycles + core busy time; result held until i_out_ready.
// Ports   : i_clk, i_resetn (async, active-low), i_dir (1=encrypt), i_iv/i_iv_load,
//           bus (serpent_cbc_ctrl_if.slave: block, result and core signals),
//           o_busy (not IDLE), o_block_cnt (completed blocks, wraps).
// Config  : SERPENT_CBC_CHAIN_EN defined -> CBC chaining; undefined -> ECB (chain held at 0,
//           i_iv_load ignored, identical handshake timing).
module serpent_cbc_ctrl (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     i_dir,
  input  logic [127:0]             i_iv,
  input  logic                     i_iv_load,
  serpent_cbc_ctrl_if.slave        bus,
  output logic                     o_busy,
  output logic [15:0]              o_block_cnt
);

`ifdef SERPENT_CBC_CHAIN_EN
  localparam bit ChainEn = 1'b1;
`else
  localparam bit ChainEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    OUT     = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic         dir_q, dir_d;
  logic [127:0] core_data_q, core_data_d;
  logic [127:0] saved_ct_q, saved_ct_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] out_data_q, out_data_d;
  logic [15:0]  cnt_q, cnt_d;

  logic         in_ready;
  logic         out_valid;
  logic         new_block;
  logic [127:0] chain_in;

  // An IV load coinciding with an accept must be seen by that very block.
  assign chain_in = (ChainEn && i_iv_load) ? i_iv : chain_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      core_data_q <= '0;
      saved_ct_q  <= '0;
      chain_q     <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      core_data_q <= core_data_d;
      saved_ct_q  <= saved_ct_d;
      chain_q     <= chain_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    core_data_d = core_data_q;
    saved_ct_d  = saved_ct_q;
    chain_d     = chain_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    new_block   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (ChainEn && i_iv_load) begin
          chain_d = i_iv;
        end
        if (bus.i_in_valid) begin
          dir_d = i_dir;
          if (i_dir) begin
            core_data_d = bus.i_in_data ^ chain_in;
          end else begin
            // Ciphertext is kept to become the next chain value once this block finishes.
            core_data_d = bus.i_in_data;
            saved_ct_d  = bus.i_in_data;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        new_block = 1'b1;
        state_d   = WAIT_LO;
      end

      // The core drops ready to acknowledge the start before it can raise it again.
      WAIT_LO: begin
        if (!bus.i_core_ready) begin
          state_d = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (bus.i_core_ready) begin
          if (dir_q) begin
            out_data_d = bus.i_core_result;
            chain_d    = ChainEn ? bus.i_core_result : '0;
          end else begin
            out_data_d = bus.i_core_result ^ chain_q;
            chain_d    = ChainEn ? saved_ct_q : '0;
          end
          state_d = OUT;
        end
      end

      OUT: begin
        out_valid = 1'b1;
        if (bus.i_out_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_in_ready       = in_ready;
  assign bus.o_out_valid      = out_valid;
  assign bus.o_out_data       = out_data_q;
  assign bus.o_core_new_block = new_block;
  assign bus.o_core_dir       = dir_q;
  assign bus.o_core_data      = core_data_q;
  assign o_busy               = (state_q != IDLE);
  assign o_block_cnt          = cnt_q;

endmodule

// File: tb/tb_serpent_cbc_ctrl.sv
// Testbench for serpent_cbc_ctrl with a mock cipher core
// (result = core_data ^ A5-pattern, ready falls one cycle after start, rises 32 later).
module tb_serpent_cbc_ctrl;

`ifdef SERPENT_CBC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  localparam logic [127:0] A5 = {16{8'hA5}};

  logic         i_clk;
  logic         i_resetn;
  logic         i_dir;
  logic [127:0] i_iv;
  logic         i_iv_load;
  logic         o_busy;
  logic [15:0]  o_block_cnt;

  serpent_cbc_ctrl_if bus();

  serpent_cbc_ctrl dut (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_dir       (i_dir),
    .i_iv        (i_iv),
    .i_iv_load   (i_iv_load),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_block_cnt (o_block_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Mock cipher core
  int unsigned mk_cnt;
  assign bus.i_core_result = bus.o_core_data ^ A5;
  always @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      bus.i_core_ready <= 1'b1;
      mk_cnt           <= 0;
    end else if (bus.o_core_new_block) begin
      mk_cnt <= 1;
    end else if (mk_cnt == 1) begin
      bus.i_core_ready <= 1'b0;
      mk_cnt           <= 2;
    end else if (mk_cnt >= 2 && mk_cnt < 33) begin
      mk_cnt <= mk_cnt + 1;
    end else if (mk_cnt == 33) begin
      bus.i_core_ready <= 1'b1;
      mk_cnt           <= 0;
    end
  end

  int vectors;
  int miscompares;

  // Reference model state
  logic [127:0] m_chain;
  logic [15:0]  m_cnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // CBC: enc C = E(P ^ chain), chain = C; dec P = D(C) ^ chain, chain = C. ECB: chain is always 0.
  task automatic model_block(input logic dir, input logic [127:0] d, input logic ld,
                             input logic [127:0] iv, output logic [127:0] exp_core,
                             output logic [127:0] exp_out);
    logic [127:0] cv;
    cv = (CHAIN && ld) ? iv : m_chain;
    if (dir) begin
      exp_core = d ^ cv;
      exp_out  = exp_core ^ A5;
      if (CHAIN) m_chain = exp_out;
    end else begin
      exp_core = d;
      exp_out  = (d ^ A5) ^ cv;
      if (CHAIN) m_chain = d;
    end
  endtask

  task automatic iv_only(input logic [127:0] iv);
    @(negedge i_clk);
    i_iv      = iv;
    i_iv_load = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_iv_load = 1'b0;
    if (CHAIN) m_chain = iv;
  endtask

  task automatic run_block(input logic dir, input logic [127:0] d, input logic ld,
                           input logic [127:0] iv, input int hold, output logic [127:0] obs);
    logic [127:0] exp_core, exp_out, cd;
    int lat;
    bit nb_bad, cd_bad;
    model_block(dir, d, ld, iv, exp_core, exp_out);
    @(negedge i_clk);
    i_dir          = dir;
    bus.i_in_data  = d;
    i_iv_load      = ld;
    i_iv           = iv;
    bus.i_in_valid = 1'b1;
    check("in_ready_idle", bus.o_in_ready, 1'b1);
    @(posedge i_clk);
    @(negedge i_clk);
    // Disturb inputs that must not affect the block in flight.
    bus.i_in_valid = 1'b0;
    i_iv_load      = 1'b0;
    i_dir          = ~dir;
    i_iv           = rnd128();
    bus.i_in_data  = rnd128();
    check("new_block_issue", bus.o_core_new_block, 1'b1);
    check("busy_issue", o_busy, 1'b1);
    check("core_dir", bus.o_core_dir, dir);
    check("core_data", bus.o_core_data, exp_core);
    cd = bus.o_core_data;
    lat = 0; nb_bad = 0; cd_bad = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      i_iv_load = (n == 5);
      if (n == 5) i_iv = rnd128();
      if (bus.o_core_new_block) nb_bad = 1;
      if (bus.o_out_valid) begin
        lat = n;
        break;
      end
      if (bus.o_core_data !== cd || bus.o_core_dir !== dir) cd_bad = 1;
    end
    i_iv_load = 1'b0;
    check("latency", lat, 35);
    check("new_block_only_issue", nb_bad, 1'b0);
    check("core_stable", cd_bad, 1'b0);
    check("out_data", bus.o_out_data, exp_out);
    obs = bus.o_out_data;
    for (int h = 0; h < hold; h++) begin
      bus.i_in_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check("hold_valid", bus.o_out_valid, 1'b1);
      check("hold_data", bus.o_out_data, exp_out);
      check("hold_in_ready", bus.o_in_ready, 1'b0);
    end
    bus.i_in_valid  = 1'b0;
    bus.i_out_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_out_ready = 1'b0;
    m_cnt = m_cnt + 16'd1;
    check("valid_drop", bus.o_out_valid, 1'b0);
    check("busy_done", o_busy, 1'b0);
    check("block_cnt", o_block_cnt, m_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] obs;
    vectors        = 0;
    miscompares    = 0;
    m_chain        = '0;
    m_cnt          = '0;
    i_resetn       = 1'b0;
    i_dir          = 1'b1;
    i_iv           = '0;
    i_iv_load      = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = '0;
    bus.i_out_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_cnt", o_block_cnt, 16'd0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_out_valid", bus.o_out_valid, 1'b0);
    check("rst_new_block", bus.o_core_new_block, 1'b0);
    check("rst_core_dir", bus.o_core_dir, 1'b1);
    check("rst_core_data", bus.o_core_data, '0);
    check("rst_out_data", bus.o_out_data, '0);
    i_resetn = 1'b1;

    // Encrypt 0 after IV 1
    iv_only(128'h1);
    run_block(1'b1, '0, 1'b0, '0, 0, obs);
    check("enc_iv1", obs, CHAIN ? (128'h1 ^ A5) : A5);

    // Two encrypts of 0 after IV 0 (IV loaded together with the first accept)
    run_block(1'b1, '0, 1'b1, '0, 0, obs);
    check("enc_chain_first", obs, A5);
    run_block(1'b1, '0, 1'b0, '0, 0, obs);
    check("enc_chain_second", obs, CHAIN ? 128'h0 : A5);
    check("cnt_three", o_block_cnt, 16'd3);

    // Decrypt F0 after IV 5, then the chain must be F0
    iv_only(128'h5);
    run_block(1'b0, 128'hF0, 1'b0, '0, 0, obs);
    check("dec_iv5", obs, CHAIN ? (128'hF0 ^ A5 ^ 128'h5) : (128'hF0 ^ A5));
    run_block(1'b1, '0, 1'b0, '0, 0, obs);
    check("chain_after_dec", obs, CHAIN ? (128'hF0 ^ A5) : A5);

    // Output backpressure for 10 cycles
    run_block(1'b1, rnd128(), 1'b0, '0, 10, obs);

    // IV load coinciding with accept
    run_block(1'b1, 128'h33, 1'b1, 128'h77, 0, obs);
    check("iv_coincide", obs, CHAIN ? (128'h33 ^ 128'h77 ^ A5) : (128'h33 ^ A5));

    // Random traffic
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) iv_only(rnd128());
      run_block(1'($urandom_range(0, 1)), rnd128(), 1'($urandom_range(0, 1)), rnd128(),
                int'($urandom_range(0, 3)), obs);
    end

    // Reset while waiting for the core to finish
    @(negedge i_clk);
    i_dir          = 1'b1;
    bus.i_in_data  = rnd128();
    bus.i_in_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_in_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    check("pre_rst_busy", o_busy, 1'b1);
    i_resetn = 1'b0;
    #1;
    m_chain = '0;
    m_cnt   = '0;
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_out_valid", bus.o_out_valid, 1'b0);
    check("mid_rst_new_block", bus.o_core_new_block, 1'b0);
    check("mid_rst_core_dir", bus.o_core_dir, 1'b1);
    check("mid_rst_core_data", bus.o_core_data, '0);
    check("mid_rst_out_data", bus.o_out_data, '0);
    check("mid_rst_cnt", o_block_cnt, 16'd0);
    @(negedge i_clk);
    i_resetn = 1'b1;
    run_block(1'b1, '0, 1'b0, '0, 0, obs);
    check("post_rst_block", obs, A5);
    check("post_rst_cnt", o_block_cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
